// File: rtl/uart_program_loader_if.sv
// BRAM port A write bus driven by the UART program loader.
// The loader drives the bus through the master modport; the BRAM-side mux sees the slave modport.
interface uart_program_loader_if;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_din
  );

  modport slave (
    input mem_we,
    input mem_addr,
    input mem_din
  );
endinterface

// File: rtl/uart_program_loader.sv
// UART program loader: receives a length-prefixed program image over 8N1 UART
// and writes it word-by-word into IMEM (BRAM port A). The core is held in reset
// until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// that must match the XOR of all length and payload bytes.
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_WORDS    = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         uart_rx,
  uart_program_loader_if.master        mem,
  output logic                         core_rst,
  output logic                         load_done,
  output logic                         load_err,
  output logic                         frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {L_LEN, L_DATA, L_FIN, L_ERR, L_CSUM} ld_state_e;
  localparam ld_state_e L_AFTER = L_CSUM;
`else
  typedef enum logic [2:0] {L_LEN, L_DATA, L_FIN, L_ERR} ld_state_e;
  localparam ld_state_e L_AFTER = L_FIN;
`endif

  // receiver state
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  // loader state
  ld_state_e       ld_state_q, ld_state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     len_q, len_d;
  logic [31:0]     word_q, word_d;
  logic [31:0]     word_idx_q, word_idx_d;
  logic [3:0]      mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_din_q, mem_din_d;
  logic            core_rst_q, core_rst_d;
  logic            load_done_q, load_done_d;
  logic            load_err_q, load_err_d;
  logic [31:0]     n_s;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  // Two-flop synchronizer for the asynchronous rx line plus a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Receiver next-state: mid-bit sampling of start, 8 data bits (LSB first) and stop bit.
  always_comb begin
    rx_state_d   = rx_state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
    case (rx_state_q)
      R_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = 3'd0;
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = R_START;
        end else begin
          rx_state_d = R_IDLE;
        end
      end
      R_START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          if (!rx_s2_q) begin
            rx_state_d = R_DATA;
          end else begin
            rx_state_d = R_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_state_d = R_STOP;
          end else begin
            rx_state_d = R_DATA;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d  = '0;
          rx_state_d = R_IDLE;
          if (rx_s2_q) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: begin
        rx_state_d = R_IDLE;
        clk_cnt_d  = '0;
      end
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q   <= R_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Word count as it stands once the current byte is taken as the 4th length byte.
  assign n_s = {shift_q, len_q[23:0]};

  // Loader next-state: length header, payload words, completion or error.
  always_comb begin
    ld_state_d = ld_state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    word_d     = word_q;
    word_idx_d = word_idx_q;
    mem_we_d   = 4'h0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (ld_state_q)
      L_LEN: begin
        if (byte_valid_q) begin
          len_d[{byte_cnt_q, 3'b000} +: 8] = shift_q;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ shift_q;
`endif
          if (byte_cnt_q == 2'd3) begin
            word_idx_d = 32'd0;
            if (n_s > 32'(MAX_WORDS)) begin
              ld_state_d = L_ERR;
            end else if (n_s == 32'd0) begin
              ld_state_d = L_AFTER;
            end else begin
              ld_state_d = L_DATA;
            end
          end else begin
            ld_state_d = L_LEN;
          end
        end else begin
          ld_state_d = L_LEN;
        end
      end
      L_DATA: begin
        if (byte_valid_q) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = shift_q;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ shift_q;
`endif
          if (byte_cnt_q == 2'd3) begin
            mem_we_d   = 4'hF;
            mem_addr_d = {word_idx_q[29:0], 2'b00};
            mem_din_d  = {shift_q, word_q[23:0]};
            word_idx_d = word_idx_q + 32'd1;
            if (word_idx_q == (len_q - 32'd1)) begin
              ld_state_d = L_AFTER;
            end else begin
              ld_state_d = L_DATA;
            end
          end else begin
            ld_state_d = L_DATA;
          end
        end else begin
          ld_state_d = L_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      L_CSUM: begin
        if (byte_valid_q) begin
          if (shift_q == csum_q) begin
            ld_state_d = L_FIN;
          end else begin
            ld_state_d = L_ERR;
          end
        end else begin
          ld_state_d = L_CSUM;
        end
      end
`endif
      L_FIN:   ld_state_d = L_FIN;
      L_ERR:   ld_state_d = L_ERR;
      default: ld_state_d = L_ERR;
    endcase

    if (ld_state_q == L_FIN) begin
      core_rst_d  = 1'b0;
      load_done_d = 1'b1;
    end else begin
      core_rst_d  = 1'b1;
      load_done_d = 1'b0;
    end

    if (ld_state_q == L_ERR) begin
      load_err_d = 1'b1;
    end else begin
      load_err_d = 1'b0;
    end
  end

  // Loader state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state_q  <= L_LEN;
      byte_cnt_q  <= 2'd0;
      len_q       <= 32'd0;
      word_q      <= 32'd0;
      word_idx_q  <= 32'd0;
      mem_we_q    <= 4'h0;
      mem_addr_q  <= 32'd0;
      mem_din_q   <= 32'd0;
      core_rst_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      ld_state_q  <= ld_state_d;
      byte_cnt_q  <= byte_cnt_d;
      len_q       <= len_d;
      word_q      <= word_d;
      word_idx_q  <= word_idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      core_rst_q  <= core_rst_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign mem.mem_we   = mem_we_q;
  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_din  = mem_din_q;
  assign core_rst     = core_rst_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign frame_err    = frame_err_q;

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Upstream boot stage for the pipelined RV32 core.
- Receives a program image over a UART RX line and writes it word-by-word into BRAM port A (IMEM), starting at address 0.
- Holds the core in reset until the image is fully loaded, then releases it.
- Port A is muxed by the parent: loader owns it while core_rst=1, the fetch stage owns it after release.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4.
- MAX_WORDS, 4096, IMEM capacity in 32-bit words; larger lengths are rejected.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- uart_rx  in  1  asynchronous serial input; idle high, 8N1, LSB first.
- mem_we  out  4  byte write enables to BRAM port A; 4'hF or 4'h0 only.
- mem_addr  out  32  byte address to BRAM port A; always word-aligned.
- mem_din  out  32  write data to BRAM port A.
- core_rst  out  1  active-high reset to the core pipeline.
- load_done  out  1  high once the image is loaded; sticky until rst.
- load_err  out  1  high on a protocol error; sticky until rst.
- frame_err  out  1  sticky; set on any byte with stop bit = 0.

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_din=0, core_rst=1, load_done=0, load_err=0, frame_err=0. RX FSM goes to R_IDLE, loader FSM to L_LEN, and all counters clear.
- Reset is synchronous and active-high. Asserting rst mid-transfer aborts immediately and re-asserts core_rst on the next edge. Partially written IMEM is not cleared.
- uart_rx input conditioning:
  - Passes through a 2-FF synchronizer before use. Synchronizer flops reset to 1.
- RX FSM:
  - R_IDLE -> R_START on a falling edge of the synced rx.
  - R_START: wait CLKS_PER_BIT/2 cycles, then sample. If 0, go to R_DATA. If 1 (glitch), return to R_IDLE.
  - R_DATA: sample every CLKS_PER_BIT cycles, 8 bits, shifted in LSB first.
  - R_STOP: sample after CLKS_PER_BIT cycles.
    - If 1: pulse byte_valid (internal) for exactly 1 cycle.
    - If 0: set frame_err and drop the byte (no byte_valid).
    - Either way, return to R_IDLE.
- Protocol: 4 length bytes (word count N, little-endian), then N words of 4 bytes each, little-endian.
- Loader FSM:
  - L_LEN: collect 4 bytes.
    - On the 4th byte: if N > MAX_WORDS, go to L_ERR.
    - If N = 0, go to L_FIN (or L_CSUM when the optional feature is compiled in).
    - Otherwise go to L_DATA with word_idx=0.
  - L_DATA: collect 4 bytes into mem_din, byte k to bits [8k+7:8k].
    - The cycle after the 4th byte_valid: mem_we=4'hF for exactly 1 cycle, mem_addr=word_idx<<2, then word_idx increments.
    - After word N-1 is written, go to L_FIN (or L_CSUM).
  - L_FIN: load_done=1. core_rst falls on the cycle after entering L_FIN.
    - The state is absorbing; further bytes are ignored.
  - L_ERR: load_err=1, core_rst stays 1, mem_we stays 0.
    - The state is absorbing until rst.
- frame_err does not change loader state. A dropped byte simply is not counted.
- mem_addr and mem_din hold their last values when mem_we=0.
- A byte_valid arriving while in L_FIN or L_ERR has no effect.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all length and payload bytes is kept.
  - After the payload, state L_CSUM takes 1 more byte.
  - Equal to the XOR: go to L_FIN. Unequal: go to L_ERR.
- Undefined:
  - No L_CSUM state and no checksum byte.
  - load_err is driven only by N > MAX_WORDS.

Test Plan (bench uses CLKS_PER_BIT=4, MAX_WORDS=16):
- Reset check: hold rst 3 cycles with uart_rx=1 -> core_rst=1, mem_we=0, load_done=0, all errors 0.
- Basic load: send N=2 (0x02,0x00,0x00,0x00), then words 0x00500093 and 0x00108133, LSB byte first.
  - Expect two 1-cycle writes: (addr 0x0, data 0x00500093) then (addr 0x4, data 0x00108133).
  - Expect load_done=1, and core_rst=0 one cycle after entering L_FIN.
- Oversize: send N=17 -> load_err=1, no mem_we pulse ever, core_rst stays 1.
- Framing: send byte 0xA5 with stop bit 0 as the first length byte, then a valid N=1 and word 0xDEADBEEF.
  - Expect frame_err=1 and a write of 0xDEADBEEF to addr 0x0, then load_done=1.
- Glitch and mid-load reset:
  - A 1-cycle low pulse on uart_rx -> no byte accepted.
  - Assert rst after 2 of 4 payload bytes -> core_rst=1, load_done=0. A fresh N=1 load after that writes addr 0x0.
- LOADER_CHECKSUM_EN: N=1, word 0x11223344.
  - Checksum byte 0x45 (XOR of 0x01, 0x44, 0x33, 0x22, 0x11) -> load_done=1.
  - Checksum byte 0x00 -> load_err=1, core_rst stays 1.
